// File: rtl/aec_pkg.sv
// Shared definitions for the expression evaluator (AEC) and its upstream feeder.
// Holds the ASCII operator constants, the feeder state type and the legal-character test.
package aec_pkg;

  localparam logic [7:0] ASC_EQ  = 8'd61;
  localparam logic [7:0] ASC_LP  = 8'd40;
  localparam logic [7:0] ASC_RP  = 8'd41;
  localparam logic [7:0] ASC_MUL = 8'd42;
  localparam logic [7:0] ASC_ADD = 8'd43;
  localparam logic [7:0] ASC_SUB = 8'd45;
  localparam logic [7:0] ASC_D0  = 8'h30;
  localparam logic [7:0] ASC_D9  = 8'h39;
  localparam logic [7:0] ASC_LA  = 8'h61;
  localparam logic [7:0] ASC_LF  = 8'h66;

  typedef enum logic [1:0] {
    LOAD,
    SEND,
    WAIT
  } state_t;

  // Digits, lowercase hex letters, parentheses, the three operators and '='.
  function automatic logic is_legal_char(input logic [7:0] c);
    return ((c >= ASC_D0) && (c <= ASC_D9)) ||
           ((c >= ASC_LA) && (c <= ASC_LF)) ||
           (c == ASC_LP)  || (c == ASC_RP)  ||
           (c == ASC_MUL) || (c == ASC_ADD) ||
           (c == ASC_SUB) || (c == ASC_EQ);
  endfunction

endpackage

// File: rtl/aec_char_buf.sv
// Character store for one expression: synchronous write, combinational read.
// Contents are not reset; only the entries below the feeder's count are ever read.
module aec_char_buf #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/aec_expr_feeder.sv
// Buffers one filtered ASCII expression from the host and replays it to AEC as a gap-free burst
// ending in '=', then holds the host off until AEC signals its result.
module aec_expr_feeder
  import aec_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] ascii_out,
  output logic              aec_ready,
  input  logic              aec_valid,
  output logic              busy,
  output logic              err_char,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [CW-1:0]     count;
  logic [CW-1:0]     rd_ptr;
  logic [7:0]        in_char;
  logic              take;
  logic              legal;
  logic              is_eq;
  logic              store;
  logic              expr_done;
  logic              last_send;
  logic [DATA_W-1:0] rd_data;

  assign in_char   = in_data[7:0];
  assign take      = in_valid && in_ready;
  assign legal     = is_legal_char(in_char);
  assign is_eq     = (in_char == ASC_EQ);
  // The last slot is kept free so the closing '=' always fits.
  assign store     = take && legal &&
                     ((!is_eq && (count < LAST_SLOT)) || (is_eq && (count != '0)));
  assign expr_done = take && is_eq && (count != '0);
  assign last_send = (rd_ptr == (count - CW'(1)));

  aec_char_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (store),
    .wr_addr (count[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (expr_done) state_next = SEND;
      SEND:    if (last_send) state_next = WAIT;
      WAIT:    if (aec_valid) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // The bus stays at 00 outside SEND so AEC never sees a stray '='.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    aec_ready = 1'b0;
    ascii_out = '0;
    case (state)
      LOAD: in_ready = 1'b1;
      SEND: begin
        busy      = 1'b1;
        ascii_out = rd_data;
        aec_ready = (rd_ptr == '0);
      end
      WAIT:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      err_char <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (store) begin
            count <= count + CW'(1);
          end
          if (take && (!legal || (is_eq && (count == '0)))) begin
            err_char <= 1'b1;
          end
          if (take && legal && !is_eq && (count == LAST_SLOT)) begin
            overflow <= 1'b1;
          end
        end
        SEND: rd_ptr <= rd_ptr + CW'(1);
        WAIT: begin
          if (aec_valid) begin
            count    <= '0;
            rd_ptr   <= '0;
            err_char <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aec_expr_feeder.sv
// Directed and randomized bench for aec_expr_feeder, checked against a queue-based model of
// the expression the host has typed so far.
module tb_aec_expr_feeder;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;

  typedef logic [7:0] charq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [DATA_W-1:0] ascii_out;
  logic              aec_ready;
  logic              aec_valid = 1'b0;
  logic              busy;
  logic              err_char;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  charq_t expQ;
  bit     expErr = 1'b0;
  bit     expOvf = 1'b0;

  aec_expr_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ascii_out (ascii_out),
    .aec_ready (aec_ready),
    .aec_valid (aec_valid),
    .busy      (busy),
    .err_char  (err_char),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic charq_t strToQ(input string s);
    charq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bit isLegal(input logic [7:0] c);
    string legalSet = "0123456789abcdef()*+-=";
    for (int i = 0; i < legalSet.len(); i++) begin
      if (legalSet[i] == c) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model of what the host has typed; returns 1 when the character launches a burst.
  function automatic bit modelPush(input logic [7:0] c);
    if (!isLegal(c)) begin
      expErr = 1'b1;
    end else if (c == 8'd61) begin
      if (expQ.size() == 0) expErr = 1'b1;
      else begin
        expQ.push_back(c);
        return 1'b1;
      end
    end else if (expQ.size() < DEPTH - 1) begin
      expQ.push_back(c);
    end else begin
      expOvf = 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_ascii"},    32'(ascii_out), 32'd0);
    checkOutput({tag, "_aec_ready"}, 32'(aec_ready), 32'd0);
    checkOutput({tag, "_busy"},     32'(busy), 32'd0);
    checkOutput({tag, "_err"},      32'(err_char), 32'd0);
    checkOutput({tag, "_ovf"},      32'(overflow), 32'd0);
  endtask

  task automatic applyStimulus(input logic [7:0] c, input bit gap);
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    checkOutput("load_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = c;
  endtask

  // gapMode: 0 back-to-back, 1 idle cycle before every char, 2 random idles.
  task automatic runExpr(input string tag, input charq_t chars, input int gapMode);
    bit started = 1'b0;
    int waitCycles;
    foreach (chars[i]) begin
      applyStimulus(chars[i], (gapMode == 1) || ((gapMode == 2) && ($urandom_range(0, 1) == 1)));
      started = modelPush(chars[i]);
      if (started) break;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!started) begin
      checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_idle_ascii"}, 32'(ascii_out), 32'd0);
      checkOutput({tag, "_idle_err"}, 32'(err_char), 32'(expErr));
      return;
    end
    for (int i = 0; i < expQ.size(); i++) begin
      if (i > 0) @(negedge clk);
      checkOutput({tag, "_burst_char"}, 32'(ascii_out), 32'(expQ[i]));
      checkOutput({tag, "_burst_rdy"}, 32'(aec_ready), 32'(i == 0));
      checkOutput({tag, "_burst_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_burst_in_ready"}, 32'(in_ready), 32'd0);
      aec_valid = (gapMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    waitCycles = $urandom_range(1, 3);
    for (int w = 0; w < waitCycles; w++) begin
      @(negedge clk);
      checkOutput({tag, "_wait_ascii"}, 32'(ascii_out), 32'd0);
      checkOutput({tag, "_wait_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_wait_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_wait_rdy"}, 32'(aec_ready), 32'd0);
      checkOutput({tag, "_wait_err"}, 32'(err_char), 32'(expErr));
      checkOutput({tag, "_wait_ovf"}, 32'(overflow), 32'(expOvf));
      in_valid  = (w < waitCycles - 1);
      in_data   = 8'h66;
      aec_valid = (w == waitCycles - 1);
    end
    @(negedge clk);
    aec_valid = 1'b0;
    in_valid  = 1'b0;
    expQ.delete();
    expErr = 1'b0;
    expOvf = 1'b0;
    checkReset({tag, "_after"});
  endtask

  function automatic charq_t randomExpr();
    string legalBody = "0123456789abcdef()*+-";
    string illegal   = "#! xyzG/";
    charq_t q;
    int len = $urandom_range(1, 22);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 9) == 0) q.push_back(illegal[$urandom_range(0, illegal.len() - 1)]);
      else q.push_back(legalBody[$urandom_range(0, legalBody.len() - 1)]);
    end
    q.push_back(8'd61);
    return q;
  endfunction

  initial begin
    charq_t ones;
    charq_t abq;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkReset("reset");
    rst = 1'b0;

    runExpr("t1", strToQ("3+4="), 0);
    runExpr("t2", strToQ("(1+2)*3="), 1);
    runExpr("t3", strToQ("2#+5="), 0);
    for (int i = 0; i < 20; i++) ones.push_back(8'h31);
    ones.push_back(8'd61);
    runExpr("t4", ones, 0);
    runExpr("t5a", strToQ("="), 0);
    runExpr("t5b", strToQ("9="), 0);

    abq = strToQ("a-b=");
    foreach (abq[i]) applyStimulus(abq[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("t6_first", 32'(ascii_out), 32'h61);
    checkOutput("t6_first_rdy", 32'(aec_ready), 32'd1);
    @(negedge clk);
    checkOutput("t6_second", 32'(ascii_out), 32'h2d);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkReset("t6_reset");
    checkOutput("t6_no_eq", 32'(ascii_out == 8'd61), 32'd0);
    runExpr("t6b", strToQ("a-b="), 0);

    for (int n = 0; n < 25; n++) runExpr("rand", randomExpr(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
